fp16_div_seq: RTL and testbench



---
 rtl/fp16_pkg.sv | 33 +++
 rtl/fp16_class.sv | 31 +++
 rtl/fp16_div_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_fp16_div_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the floating-point datapath blocks.
// Holds the field widths, the exponent bias, the fixed result magnitudes,
// the divider FSM state type and the one-hot result-class flag vector type.
package fp16_pkg;

    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 10;
    localparam int FP_BIAS  = 15;

    // Result magnitudes; the sign bit is prepended by the user.
    localparam logic [14:0] QNAN_DEFAULT = 15'h7E2A;
    localparam logic [14:0] INF_MAG      = 15'h7C00;
    localparam logic [14:0] ZERO_MAG     = 15'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_ROUND,
        S_DONE
    } div_state_t;

    // One-hot class of a half-precision value.
    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic zero;
        logic subnormal;
        logic normal;
    } fp_flags_t;

endpackage

// File: rtl/fp16_class.sv
// FP16 operand classifier.
// Ports:
//   mag - exponent and mantissa fields of the operand (sign not needed)
//   cls - one-hot class: snan, qnan, inf, zero, subnormal, normal
module fp16_class
    import fp16_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic [EXP_W+MAN_W-1:0] mag,
    output fp_flags_t              cls
);

    logic exp_ones;
    logic exp_zero;
    logic man_nz;

    assign exp_ones = &mag[EXP_W+MAN_W-1:MAN_W];
    assign exp_zero = ~|mag[EXP_W+MAN_W-1:MAN_W];
    assign man_nz   = |mag[MAN_W-1:0];

    // The mantissa MSB distinguishes quiet from signalling NaNs.
    assign cls.snan      = exp_ones & man_nz & ~mag[MAN_W-1];
    assign cls.qnan      = exp_ones & mag[MAN_W-1];
    assign cls.inf       = exp_ones & ~man_nz;
    assign cls.zero      = exp_zero & ~man_nz;
    assign cls.subnormal = exp_zero & man_nz;
    assign cls.normal    = ~exp_ones & ~exp_zero;

endmodule

// File: rtl/fp16_div_seq.sv
// Sequential IEEE 754 half-precision divider, quotient = na / nb.
// Restoring mantissa division, one quotient bit per cycle, round to nearest
// even, subnormal inputs treated as zero and tiny results flushed to zero.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start             - request, accepted in IDLE or DONE
//   na, nb            - dividend / divisor, latched with an accepted start
//   busy              - high while in PREP, DIV or ROUND
//   done              - one-cycle pulse while in DONE
//   quotient          - result, held until the next accepted start
//   snan..normal, dz  - one-hot result class and divide-by-zero flag
module fp16_div_seq
    import fp16_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int BIAS  = FP_BIAS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] na,
    input  logic [EXP_W+MAN_W:0] nb,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] quotient,
    output logic                 snan,
    output logic                 qnan,
    output logic                 inf,
    output logic                 zero,
    output logic                 subnormal,
    output logic                 normal,
    output logic                 dz
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int EW    = EXP_W + 2;    // signed exponent with over/underflow headroom
    localparam int SW    = MAN_W + 1;    // significand including hidden bit
    localparam int RW    = MAN_W + 2;    // partial remainder
    localparam int CNT_W = 4;
    // Registered iterations produce the significand; the guard bit is
    // resolved in the ROUND cycle so the normal path completes in 14 edges.
    localparam int DIV_ITERS = SW;
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);

    div_state_t              state;
    logic [W-1:0]            a_r, b_r;
    logic [SW-1:0]           mb_r, q_r;
    logic [RW-1:0]           r_r;
    logic signed [EW-1:0]    e_r;
    logic                    sign_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [W-1:0]            quot_r;
    fp_flags_t               flags_r;
    logic                    dz_r, busy_r, done_r;

    function automatic logic [SW:0] rne(input logic [SW-1:0] sig,
                                        input logic guard,
                                        input logic sticky);
        logic up;
        up = guard & (sticky | sig[0]);
        return {1'b0, sig} + {{SW{1'b0}}, up};
    endfunction

    fp_flags_t ca, cb;

    fp16_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (.mag(a_r[W-2:0]), .cls(ca));
    fp16_class #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (.mag(b_r[W-2:0]), .cls(cb));

    // Special-case decode on the latched operands, in priority order.
    logic            sign_c, za, zb, spec_hit, spec_dz;
    logic [W-1:0]    spec_q;
    fp_flags_t       spec_f;

    assign sign_c = a_r[W-1] ^ b_r[W-1];
    assign za     = ca.zero | ca.subnormal;
    assign zb     = cb.zero | cb.subnormal;

    always_comb begin
        spec_hit = 1'b1;
        spec_q   = '0;
        spec_f   = '0;
        spec_dz  = 1'b0;
        if (ca.snan | cb.snan) begin
            spec_q      = ca.snan ? a_r : b_r;
            spec_f.snan = 1'b1;
        end else if (ca.qnan | cb.qnan) begin
            spec_q      = ca.qnan ? a_r : b_r;
            spec_f.qnan = 1'b1;
        end else if ((ca.inf & cb.inf) | (za & zb)) begin
            spec_q      = {sign_c, QNAN_DEFAULT};
            spec_f.qnan = 1'b1;
        end else if (ca.inf) begin
            spec_q     = {sign_c, INF_MAG};
            spec_f.inf = 1'b1;
        end else if (zb) begin
            spec_q     = {sign_c, INF_MAG};
            spec_f.inf = 1'b1;
            spec_dz    = 1'b1;
        end else if (!(ca.normal & cb.normal)) begin
            // dividend zero or divisor infinite
            spec_q      = {sign_c, ZERO_MAG};
            spec_f.zero = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Operand preparation for the normal path.
    logic [SW-1:0]        ma_c, mb_c;
    logic signed [EW-1:0] e_c;

    assign ma_c = {1'b1, a_r[MAN_W-1:0]};
    assign mb_c = {1'b1, b_r[MAN_W-1:0]};
    assign e_c  = $signed({2'b00, a_r[W-2:MAN_W]}) - $signed({2'b00, b_r[W-2:MAN_W]}) + BIAS_S;

    // One restoring step: also yields the guard bit and sticky in ROUND.
    logic            div_ge;
    logic [RW-1:0]   div_diff;

    assign div_ge   = (r_r >= {1'b0, mb_r});
    assign div_diff = r_r - {1'b0, mb_r};

    logic [SW:0]          sig_c;
    logic signed [EW-1:0] e_adj;
    logic [W-1:0]         rnd_q;
    fp_flags_t            rnd_f;

    assign sig_c = rne(q_r, div_ge, div_ge ? (|div_diff) : (|r_r));
    // The integer part of the rounded significand is 1, or 2 after a carry;
    // adding it minus one bumps the exponent exactly when rounding carried.
    assign e_adj = e_r - ONE_S + $signed({{(EW-2){1'b0}}, sig_c[SW:MAN_W]});

    always_comb begin
        rnd_f = '0;
        if (e_adj >= EMAX_S) begin
            rnd_q     = {sign_r, INF_MAG};
            rnd_f.inf = 1'b1;
        end else if (e_adj <= ZERO_S) begin
            rnd_q      = {sign_r, ZERO_MAG};
            rnd_f.zero = 1'b1;
        end else begin
            // After a carry the low mantissa bits are already zero.
            rnd_q        = {sign_r, e_adj[EXP_W-1:0], sig_c[MAN_W-1:0]};
            rnd_f.normal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            mb_r    <= '0;
            q_r     <= '0;
            r_r     <= '0;
            e_r     <= '0;
            sign_r  <= 1'b0;
            cnt_r   <= '0;
            quot_r  <= '0;
            flags_r <= '0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r    <= na;
                        b_r    <= nb;
                        busy_r <= 1'b1;
                        state  <= S_PREP;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_PREP: begin
                    sign_r <= sign_c;
                    if (spec_hit) begin
                        quot_r  <= spec_q;
                        flags_r <= spec_f;
                        dz_r    <= spec_dz;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        mb_r  <= mb_c;
                        q_r   <= '0;
                        cnt_r <= '0;
                        // Pre-shift keeps the first quotient bit at 1.
                        if (ma_c < mb_c) begin
                            r_r <= {ma_c, 1'b0};
                            e_r <= e_c - ONE_S;
                        end else begin
                            r_r <= {1'b0, ma_c};
                            e_r <= e_c;
                        end
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    q_r   <= {q_r[SW-2:0], div_ge};
                    r_r   <= div_ge ? {div_diff[RW-2:0], 1'b0} : {r_r[RW-2:0], 1'b0};
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == CNT_W'(DIV_ITERS - 1))
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    quot_r  <= rnd_q;
                    flags_r <= rnd_f;
                    dz_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state   <= S_DONE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign snan      = flags_r.snan;
    assign qnan      = flags_r.qnan;
    assign inf       = flags_r.inf;
    assign zero      = flags_r.zero;
    assign subnormal = flags_r.subnormal;
    assign normal    = flags_r.normal;
    assign dz        = dz_r;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: directed cases plus randomized
// operands compared against an exact integer-division reference model.
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] na, nb;
    logic        busy, done;
    logic [15:0] quotient;
    logic        snan, qnan, inf, zero, subnormal, normal, dz;

    int total = 0;
    int bad   = 0;

    fp16_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .na        (na),
        .nb        (nb),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .snan      (snan),
        .qnan      (qnan),
        .inf       (inf),
        .zero      (zero),
        .subnormal (subnormal),
        .normal    (normal),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] obs_flags();
        return {snan, qnan, inf, zero, subnormal, normal, dz};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference: value = (ma/mb) * 2^(ea-eb), evaluated by wide integer
    // division, then rounded to nearest even. Flags {snan,qnan,inf,zero,sub,normal,dz}.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [6:0] f,
                                    output int lat);
        int     ea, eb, fa, fb, ex, sh;
        bit     s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_z, b_z;
        longint ma, mb, n, rm, sig, rest, half;
        ea = a[14:10]; eb = b[14:10]; fa = a[9:0]; fb = b[9:0];
        s      = a[15] ^ b[15];
        a_nan  = (ea == 31) && (fa != 0);
        b_nan  = (eb == 31) && (fb != 0);
        a_snan = a_nan && !a[9];
        b_snan = b_nan && !b[9];
        a_inf  = (ea == 31) && (fa == 0);
        b_inf  = (eb == 31) && (fb == 0);
        a_z    = (ea == 0);   // subnormals count as zero
        b_z    = (eb == 0);
        lat = 2;
        q   = 16'h0000;
        f   = 7'b0;
        if (a_snan || b_snan) begin
            q = a_snan ? a : b;  f = 7'b1000000;
        end else if (a_nan || b_nan) begin
            q = a_nan ? a : b;   f = 7'b0100000;
        end else if ((a_inf && b_inf) || (a_z && b_z)) begin
            q = {s, 15'h7E2A};   f = 7'b0100000;
        end else if (a_inf) begin
            q = {s, 15'h7C00};   f = 7'b0010000;
        end else if (b_z) begin
            q = {s, 15'h7C00};   f = 7'b0010001;
        end else if (a_z || b_inf) begin
            q = {s, 15'h0000};   f = 7'b0001000;
        end else begin
            lat  = 14;
            ma   = 1024 + fa;
            mb   = 1024 + fb;
            n    = (ma <<< 30) / mb;
            rm   = (ma <<< 30) % mb;
            sh   = (n >= (longint'(1) <<< 30)) ? 20 : 19;
            ex   = ea - eb + ((sh == 20) ? 15 : 14);
            sig  = n >>> sh;
            rest = n - (sig <<< sh);
            half = longint'(1) <<< (sh - 1);
            if (rest > half || (rest == half && (rm != 0 || (sig % 2) == 1)))
                sig++;
            if (sig == 2048) begin
                sig = 1024;
                ex++;
            end
            if (ex >= 31) begin
                q = {s, 15'h7C00}; f = 7'b0010000;
            end else if (ex <= 0) begin
                q = {s, 15'h0000}; f = 7'b0001000;
            end else begin
                q = {s, ex[4:0], sig[9:0]}; f = 7'b0000010;
            end
        end
    endfunction

    // One transaction. glitch>0 re-pulses start (with other operands) after
    // edge number 'glitch' while busy; has_want adds a literal quotient check.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int glitch, input bit has_want, input logic [15:0] want);
        logic [15:0] eq;
        logic [6:0]  ef;
        int          elat, n;
        bit          busy_ok;
        ref_div(a, b, eq, ef, elat);
        @(negedge clk);
        na = a; nb = b; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == glitch) begin
                na = ~a; nb = ~b; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, ".latency"}, n, elat);
        check({tag, ".busy_run"}, {31'b0, busy_ok}, 1);
        check({tag, ".done"}, {31'b0, done}, 1);
        check({tag, ".busy_at_done"}, {31'b0, busy}, 0);
        check({tag, ".quotient"}, {16'b0, quotient}, {16'b0, eq});
        check({tag, ".flags"}, {25'b0, obs_flags()}, {25'b0, ef});
        if (has_want) check({tag, ".literal"}, {16'b0, quotient}, {16'b0, want});
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {31'b0, done}, 0);
        check({tag, ".hold"}, {16'b0, quotient}, {16'b0, eq});
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        na    = 16'h0000;
        nb    = 16'h0000;
        #12;
        check("reset.busy", {31'b0, busy}, 0);
        check("reset.done", {31'b0, done}, 0);
        check("reset.quotient", {16'b0, quotient}, 0);
        check("reset.flags", {25'b0, obs_flags()}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div6by2",   16'h4600, 16'h4000, 0, 1'b1, 16'h4200);
        run_op("div1by3",   16'h3C00, 16'h4200, 0, 1'b1, 16'h3555);
        run_op("div1bym0",  16'h3C00, 16'h8000, 0, 1'b1, 16'hFC00);
        run_op("div0by0",   16'h0000, 16'h0000, 0, 1'b1, 16'h7E2A);
        run_op("snan",      16'h7C01, 16'h7E00, 1, 1'b1, 16'h7C01);
        run_op("ignore_st", 16'h4600, 16'h4000, 5, 1'b1, 16'h4200);
        run_op("underflow", 16'h0400, 16'h4800, 0, 1'b1, 16'h0000);
        run_op("overflow",  16'h7BFF, 16'h1400, 0, 1'b1, 16'h7C00);

        // Reset during the fifth DIV cycle, with a non-zero held result.
        @(negedge clk);
        na = 16'h4600; nb = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset.busy_before", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midreset.busy", {31'b0, busy}, 0);
        check("midreset.done", {31'b0, done}, 0);
        check("midreset.quotient", {16'b0, quotient}, 0);
        check("midreset.flags", {25'b0, obs_flags()}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 16'h4600, 16'h4000, 0, 1'b1, 16'h4200);

        // Randomized operands: fully random encodings, then normals whose
        // exponents keep most results in the normal range.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op("rand_any", ra, rb, 0, 1'b0, 16'h0000);
        end
        for (int i = 0; i < 30; i++) begin
            ra = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
            rb = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
            run_op("rand_norm", ra, rb, 0, 1'b0, 16'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
